i2c_line_conditioner: RTL and testbench

//   Input conditioning stage between the SCL/SDA pads (io_in[8]/io_in[9]) and the I2C master's scl_i/sda_i.

---
 rtl/i2c_line_conditioner.sv | 174 +++++++++++++++++
 tb/tb_i2c_line_conditioner.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_line_conditioner.sv
// -----------------------------------------------------------------------------
// i2c_line_conditioner
//
// Receive-side conditioning between the SCL/SDA pads and an I2C master.
// Each line is synchronised, then deglitched: a new level is only accepted
// after FILT_CYCLES consecutive synchronised samples disagree with the current
// filtered level. START/STOP conditions are decoded from the filtered lines,
// a bus-busy flag is tracked, and lines held low too long are flagged as stuck.
// The open-drain drive path is not part of this block.
//
// Parameters:
//   SYNC_STAGES     synchroniser flops per line (>= 2)
//   FILT_CYCLES     consecutive differing samples to accept a change (>= 1)
//   TIMEOUT_CYCLES  low-time before a stuck flag; 0 removes stuck detection
//
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous, active-high reset
//   scl_pad_i    raw SCL from pad
//   sda_pad_i    raw SDA from pad
//   scl_f_o      filtered SCL
//   sda_f_o      filtered SDA
//   start_o      1-cycle pulse on START or repeated START
//   rstart_o     1-cycle pulse on repeated START (START while busy)
//   stop_o       1-cycle pulse on STOP
//   busy_o       bus owned (between START and STOP); this is the FSM state
//   scl_stuck_o  filtered SCL low for >= TIMEOUT_CYCLES
//   sda_stuck_o  filtered SDA low for >= TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module i2c_line_conditioner #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILT_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_pad_i,
    input  logic sda_pad_i,
    output logic scl_f_o,
    output logic sda_f_o,
    output logic start_o,
    output logic rstart_o,
    output logic stop_o,
    output logic busy_o,
    output logic scl_stuck_o,
    output logic sda_stuck_o
);

    localparam int FW = $clog2(FILT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYCLES - 1);

    localparam logic IDLE = 1'b0;
    localparam logic BUSY = 1'b1;

    // Bit 0 carries SCL, bit 1 carries SDA throughout.
    logic [1:0] pad;
    logic [1:0] filt;
    logic [1:0] stuck;

    assign pad = {sda_pad_i, scl_pad_i};

    // ---------------------------------------------------------------------
    // Synchroniser and glitch filter, one per line
    // ---------------------------------------------------------------------
    for (genvar i = 0; i < 2; i++) begin : g_line
        logic [SYNC_STAGES-1:0] sync;
        logic [FW-1:0]          cnt;
        logic                   f;

        // Reset to 1 so an idle (pulled-up) bus produces no transitions.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                sync <= '1;
                cnt  <= '0;
                f    <= 1'b1;
            end else begin
                sync <= {sync[SYNC_STAGES-2:0], pad[i]};
                // Any agreeing sample restarts the run of differing samples.
                if (sync[SYNC_STAGES-1] == f) begin
                    cnt <= '0;
                end else if (cnt == FILT_LAST) begin
                    f   <= sync[SYNC_STAGES-1];
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign filt[i] = f;
    end

    // ---------------------------------------------------------------------
    // Stuck-low detection
    // ---------------------------------------------------------------------
    if (TIMEOUT_CYCLES > 0) begin : g_stuck
        localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
        localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);
        localparam logic [TW-1:0] T_PRE = TW'(TIMEOUT_CYCLES - 1);

        for (genvar j = 0; j < 2; j++) begin : g_line
            logic [TW-1:0] cnt;
            logic          stuck_r;

            // Counter saturates at T_MAX; the flag rises on the same edge
            // the count reaches the timeout.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    cnt     <= '0;
                    stuck_r <= 1'b0;
                end else if (filt[j]) begin
                    cnt     <= '0;
                    stuck_r <= 1'b0;
                end else begin
                    if (cnt != T_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (cnt >= T_PRE) begin
                        stuck_r <= 1'b1;
                    end
                end
            end

            assign stuck[j] = stuck_r;
        end
    end else begin : g_no_stuck
        assign stuck = 2'b00;
    end

    // ---------------------------------------------------------------------
    // START/STOP decode and bus-busy state
    // ---------------------------------------------------------------------
    logic scl_q;
    logic sda_q;
    logic state;
    logic start_det;
    logic stop_det;

    // SCL must be high both before and after, so simultaneous SCL/SDA
    // changes never decode as an event.
    assign start_det = scl_q & filt[0] &  sda_q & ~filt[1];
    assign stop_det  = scl_q & filt[0] & ~sda_q &  filt[1];

    // Previous-value flops reset to 1 to match the filtered lines, which
    // keeps reset release free of spurious events.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            state    <= IDLE;
            start_o  <= 1'b0;
            rstart_o <= 1'b0;
            stop_o   <= 1'b0;
        end else begin
            scl_q    <= filt[0];
            sda_q    <= filt[1];
            start_o  <= start_det;
            rstart_o <= start_det && (state == BUSY);
            stop_o   <= stop_det;
            case (state)
                IDLE:    if (start_det) state <= BUSY;
                BUSY:    if (stop_det)  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign scl_f_o     = filt[0];
    assign sda_f_o     = filt[1];
    assign busy_o      = (state == BUSY);
    assign scl_stuck_o = stuck[0];
    assign sda_stuck_o = stuck[1];

endmodule

// File: tb/tb_i2c_line_conditioner.sv
// -----------------------------------------------------------------------------
// tb_i2c_line_conditioner
//
// Directed scenarios followed by randomized pad activity. A reference model
// derives expected outputs from the pad history: the synchronised value is the
// pad value delayed by SYNC edges, a filtered line flips when the last FILT
// synchronised samples all disagree with it, events come from the last two
// filtered levels, and stuck flags come from the run length of low levels.
// -----------------------------------------------------------------------------
module tb_i2c_line_conditioner;

    localparam int SYNC = 2;
    localparam int FILT = 4;
    localparam int TMO  = 100;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    logic scl_pad;
    logic sda_pad;

    logic scl_f, sda_f, start_p, rstart_p, stop_p, busy, scl_stuck, sda_stuck;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    i2c_line_conditioner #(
        .SYNC_STAGES   (SYNC),
        .FILT_CYCLES   (FILT),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .scl_pad_i  (scl_pad),
        .sda_pad_i  (sda_pad),
        .scl_f_o    (scl_f),
        .sda_f_o    (sda_f),
        .start_o    (start_p),
        .rstart_o   (rstart_p),
        .stop_o     (stop_p),
        .busy_o     (busy),
        .scl_stuck_o(scl_stuck),
        .sda_stuck_o(sda_stuck)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    bit pipe[2][$];   // pad values in flight through the synchroniser
    bit win[2][$];    // most recent FILT synchronised samples
    bit m_f[2];       // filtered level after the latest edge
    bit m_fq[2];      // filtered level one edge earlier
    int m_run[2];     // consecutive edges the filtered line has been low
    bit m_stk[2];
    bit m_busy, m_start, m_rstart, m_stop;

    function automatic void m_reset();
        for (int l = 0; l < 2; l++) begin
            pipe[l] = {};
            for (int k = 0; k < SYNC; k++) pipe[l].push_back(1'b1);
            win[l]   = {};
            m_f[l]   = 1'b1;
            m_fq[l]  = 1'b1;
            m_run[l] = 0;
            m_stk[l] = 1'b0;
        end
        m_busy = 1'b0; m_start = 1'b0; m_rstart = 1'b0; m_stop = 1'b0;
    endfunction

    function automatic void m_step(input bit p_scl, input bit p_sda);
        bit evt_start, evt_stop, s, all_diff;
        bit pads[2];
        pads[0] = p_scl;
        pads[1] = p_sda;
        evt_start = m_fq[0] && m_f[0] && m_fq[1] && !m_f[1];
        evt_stop  = m_fq[0] && m_f[0] && !m_fq[1] && m_f[1];
        m_start  = evt_start;
        m_rstart = evt_start && m_busy;
        m_stop   = evt_stop;
        if (evt_start) m_busy = 1'b1;
        else if (evt_stop) m_busy = 1'b0;
        for (int l = 0; l < 2; l++) begin
            m_stk[l] = !m_f[l] && (m_run[l] >= TMO);
            m_fq[l]  = m_f[l];
            s = pipe[l].pop_front();
            pipe[l].push_back(pads[l]);
            win[l].push_back(s);
            if (win[l].size() > FILT) void'(win[l].pop_front());
            if (win[l].size() == FILT) begin
                all_diff = 1'b1;
                foreach (win[l][k]) if (win[l][k] == m_f[l]) all_diff = 1'b0;
                if (all_diff) m_f[l] = !m_f[l];
            end
            m_run[l] = m_f[l] ? 0 : m_run[l] + 1;
        end
    endfunction

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [7:0] sb_exp, sb_got;
    int n_start_seen = 0, n_stop_seen = 0;

    always @(posedge clk) begin
        if (rst) m_reset();
        else m_step(scl_pad, sda_pad);
        exp_q.push_back({m_f[1], m_f[0], m_start, m_rstart, m_stop, m_busy, m_stk[0], m_stk[1]});
        #1;
        sb_got = {sda_f, scl_f, start_p, rstart_p, stop_p, busy, scl_stuck, sda_stuck};
        sb_exp = exp_q.pop_front();
        check("sda_f_o",     32'(sb_got[7]), 32'(sb_exp[7]));
        check("scl_f_o",     32'(sb_got[6]), 32'(sb_exp[6]));
        check("start_o",     32'(sb_got[5]), 32'(sb_exp[5]));
        check("rstart_o",    32'(sb_got[4]), 32'(sb_exp[4]));
        check("stop_o",      32'(sb_got[3]), 32'(sb_exp[3]));
        check("busy_o",      32'(sb_got[2]), 32'(sb_exp[2]));
        check("scl_stuck_o", 32'(sb_got[1]), 32'(sb_exp[1]));
        check("sda_stuck_o", 32'(sb_got[0]), 32'(sb_exp[0]));
        if (start_p) n_start_seen++;
        if (stop_p)  n_stop_seen++;
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit scl_v, input bit sda_v, input int cycles);
        @(negedge clk);
        scl_pad = scl_v;
        sda_pad = sda_v;
        repeat (cycles - 1) @(negedge clk);
    endtask

    // Change pads at a negedge, then watch up to 'limit' posedges and report
    // the first cycle (1-based) at which each observation held.
    task automatic change_and_watch(input bit scl_v, input bit sda_v, input int limit,
                                    output int sda_fall, output int st, output int rs,
                                    output int sp);
        sda_fall = 0; st = 0; rs = 0; sp = 0;
        @(negedge clk);
        scl_pad = scl_v;
        sda_pad = sda_v;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #2;
            if (sda_f == sda_v && sda_fall == 0) sda_fall = i;
            if (start_p  && st == 0) st = i;
            if (rstart_p && rs == 0) rs = i;
            if (stop_p   && sp == 0) sp = i;
        end
    endtask

    // ---------------- stimulus ----------------
    int lat, st, rs, sp, s0, p0, fall_at, stuck_at, rise_at, clear_at;
    bit r_scl, r_sda;

    initial begin
        rst = 1'b1; scl_pad = 1'b1; sda_pad = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle bus
        drive(1, 1, 50);
        #1;
        check("idle_scl_f", scl_f, 1);
        check("idle_sda_f", sda_f, 1);
        check("idle_busy", busy, 0);
        check("idle_no_pulses", n_start_seen + n_stop_seen, 0);

        // 3-cycle SDA glitch is rejected
        s0 = n_start_seen;
        drive(1, 0, 3);
        drive(1, 1, 20);
        check("glitch3_no_start", n_start_seen - s0, 0);
        check("glitch3_busy", busy, 0);

        // 4-cycle SDA glitch is accepted: START then STOP
        s0 = n_start_seen; p0 = n_stop_seen;
        drive(1, 0, 4);
        drive(1, 1, 20);
        check("glitch4_start", n_start_seen - s0, 1);
        check("glitch4_stop", n_stop_seen - p0, 1);

        // Clean START: latency and busy
        change_and_watch(1, 0, 12, lat, st, rs, sp);
        check("start_sda_latency", lat, 6);
        check("start_cycle", st, 7);
        check("start_not_rstart", rs, 0);
        check("start_busy", busy, 1);

        // Repeated START while busy
        drive(0, 0, 10);
        drive(0, 1, 10);
        drive(1, 1, 10);
        change_and_watch(1, 0, 12, lat, st, rs, sp);
        check("rstart_start_cycle", st, 7);
        check("rstart_cycle", rs, 7);
        check("rstart_busy", busy, 1);

        // STOP
        change_and_watch(1, 1, 12, lat, st, rs, sp);
        check("stop_cycle", sp, 7);
        check("stop_busy", busy, 0);

        // Simultaneous fall of SCL and SDA: no START
        s0 = n_start_seen;
        drive(0, 0, 20);
        check("simul_no_start", n_start_seen - s0, 0);
        check("simul_busy", busy, 0);
        drive(1, 0, 20);
        change_and_watch(1, 1, 12, lat, st, rs, sp);
        check("idle_stop_cycle", sp, 7);
        check("idle_stop_busy", busy, 0);

        // Stuck SCL
        fall_at = 0; stuck_at = 0;
        @(negedge clk);
        scl_pad = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #2;
            if (!scl_f && fall_at == 0) fall_at = i;
            if (scl_stuck && stuck_at == 0) stuck_at = i;
        end
        check("scl_stuck_seen", (stuck_at != 0), 1);
        check("scl_stuck_delay", stuck_at - fall_at, TMO);
        rise_at = 0; clear_at = 0;
        @(negedge clk);
        scl_pad = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #2;
            if (scl_f && rise_at == 0) rise_at = i;
            if (!scl_stuck && clear_at == 0) clear_at = i;
        end
        check("scl_stuck_clear", clear_at - rise_at, 1);
        drive(1, 1, 10);

        // Reset mid-transfer with SDA low
        drive(1, 0, 15);
        check("pre_rst_busy", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_sda_f", sda_f, 1);
        check("async_rst_scl_f", scl_f, 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        s0 = n_start_seen; p0 = n_stop_seen;
        repeat (3) @(negedge clk);
        check("rst_release_no_pulse", (n_start_seen - s0) + (n_stop_seen - p0), 0);
        check("rst_release_busy", busy, 0);
        drive(1, 0, 20);
        drive(1, 1, 20);

        // Randomized pad activity
        for (int n = 0; n < 400; n++) begin
            r_scl = 1'($urandom_range(0, 1));
            r_sda = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 59) == 0) begin
                @(negedge clk);
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) drive(r_scl, r_sda, $urandom_range(95, 130));
            else drive(r_scl, r_sda, $urandom_range(1, 8));
        end
        drive(1, 1, 30);
        @(posedge clk);
        #3;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
